mem_port_arbiter: RTL and testbench

- Arbitrates the single shared data memory port between the instruction-fetch unit and the load/store unit of the RV32I core.
- Sequences each granted access onto the memory's write_mem/funct3/address/data interface.
- Routes the one-cycle-latency read data back to the requester that issued it, and rejects misaligned data accesses.
- Sits between the core front end / LSU and the memory module. Also includes a starvation guard so instruction fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between instruction fetch and the load/store unit.
// Grants are combinational, read data returns one cycle later, misaligned data accesses are rejected.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  mem_write,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [31:0]           mem_read_data
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  // Owner of the read data that arrives in the following cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2,
    RESP_ERR  = 2'd3
  } resp_e;

  resp_e         resp_q, resp_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          d_misaligned;
  logic          fetch_forced;
  logic          unused_if_addr_bits;

  assign unused_if_addr_bits = ^if_addr[1:0];

  // Handshake: a requester raises req with its fields and holds both stable
  // until the cycle its gnt is high; the access is taken in that same cycle,
  // and any read data is qualified by rvalid exactly one cycle later.
  assign d_misaligned = ((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                        ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));

  assign fetch_forced = if_req && (streak_q == STREAK_MAX);

  always_comb begin
    if_gnt            = 1'b0;
    d_gnt             = 1'b0;
    mem_write         = 1'b0;
    mem_funct3        = 3'b010;
    mem_read_address  = {if_addr[ADDR_WIDTH-1:2], 2'b00};
    mem_write_address = d_addr;
    mem_write_data    = d_wdata;
    resp_d            = RESP_NONE;
    if (!reset) begin
      if (d_req && !fetch_forced) begin
        d_gnt      = 1'b1;
        mem_funct3 = d_funct3;
        if (d_misaligned) begin
          resp_d = RESP_ERR;
        end else if (d_we) begin
          mem_write = 1'b1;
        end else begin
          mem_read_address = d_addr;
          resp_d           = RESP_D;
        end
      end else if (if_req) begin
        if_gnt = 1'b1;
        resp_d = RESP_IF;
      end
    end
  end

  // Counts data wins while fetch is waiting; saturates at the forcing threshold.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q   <= RESP_NONE;
      streak_q <= '0;
    end else begin
      resp_q   <= resp_d;
      streak_q <= streak_d;
    end
  end

  // Gating with reset drops a response whose grant preceded a reset.
  assign if_rvalid = !reset && (resp_q == RESP_IF);
  assign d_rvalid  = !reset && (resp_q == RESP_D);
  assign d_err     = !reset && (resp_q == RESP_ERR);
  assign if_rdata  = mem_read_data;
  assign d_rdata   = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array reference model, directed steps, then random traffic.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]    d_funct3;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic          mem_write;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic [31:0]   mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  // Word-organised memory with one-cycle read latency and funct3 extension.
  logic [31:0] mem_w [256];
  always @(posedge clk) begin
    logic [31:0] w, m, rd;
    int sh;
    w = mem_w[mem_read_address[9:2]] >> (8 * int'(mem_read_address[1:0]));
    case (mem_funct3)
      3'b000:  rd = {{24{w[7]}}, w[7:0]};
      3'b001:  rd = {{16{w[15]}}, w[15:0]};
      3'b100:  rd = {24'h0, w[7:0]};
      3'b101:  rd = {16'h0, w[15:0]};
      default: rd = w;
    endcase
    mem_read_data <= rd;
    if (mem_write) begin
      sh = 8 * int'(mem_write_address[1:0]);
      case (mem_funct3[1:0])
        2'b00:   m = 32'h0000_00ff << sh;
        2'b01:   m = 32'h0000_ffff << sh;
        default: m = 32'hffff_ffff;
      endcase
      mem_w[mem_write_address[9:2]] = (mem_w[mem_write_address[9:2]] & ~m) |
                                      ((mem_write_data << sh) & m);
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [1024];
  int          streak_m;
  logic [31:0] exp_q [$];
  int          kind_q [$];
  logic        last_if, last_d;
  logic        obs_if, obs_d;
  logic [31:0] obs_d_rdata;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h0050_0093;
    return (32'(i) * 32'h0100_0193) ^ 32'ha5a5_5a5a;
  endfunction

  function automatic logic [31:0] ref_word(int a);
    return 32'(ref_mem[a]) + (32'(ref_mem[a+1]) << 8) +
           (32'(ref_mem[a+2]) << 16) + (32'(ref_mem[a+3]) << 24);
  endfunction

  function automatic logic [31:0] ref_load(int a, logic [2:0] f3);
    int v;
    case (f3)
      3'b000: begin v = ref_mem[a]; return (v >= 128) ? 32'(v - 256) : 32'(v); end
      3'b001: begin
        v = ref_mem[a] + 256 * ref_mem[a+1];
        return (v >= 32768) ? 32'(v - 65536) : 32'(v);
      end
      3'b100: return 32'(ref_mem[a]);
      3'b101: return 32'(ref_mem[a] + 256 * ref_mem[a+1]);
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(int a, logic [2:0] f3, logic [31:0] w);
    int n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) ref_mem[a+k] = 8'(w >> (8 * k));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the previous cycle's response and this cycle's
  // arbitration against the model, then advance to just after the next edge.
  task automatic step();
    int          pk, kind, a, size;
    logic [31:0] pd, dat;
    logic        e_if, e_d, mis;
    @(negedge clk);
    pk = (kind_q.size() > 0) ? kind_q.pop_front() : 0;
    pd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    if (reset) pk = 0;
    obs_if = if_gnt;
    obs_d = d_gnt;
    obs_d_rdata = d_rdata;
    chk("if_rvalid", 32'(if_rvalid), 32'(pk == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(pk == 2));
    chk("d_err", 32'(d_err), 32'(pk == 3));
    if (pk == 1) chk("if_rdata", if_rdata, pd);
    if (pk == 2) chk("d_rdata", d_rdata, pd);

    e_if = 1'b0;
    e_d  = 1'b0;
    if (!reset) begin
      if (d_req && !(if_req && streak_m >= MAX)) e_d = 1'b1;
      else if (if_req) e_if = 1'b1;
    end
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("d_gnt", 32'(d_gnt), 32'(e_d));

    a    = int'(d_addr) % 1024;
    size = 1 << d_funct3[1:0];
    mis  = (d_funct3[1:0] == 2'b01 || d_funct3[1:0] == 2'b10) && (a % size != 0);
    chk("mem_write", 32'(mem_write), 32'(e_d && d_we && !mis));
    kind = 0;
    dat  = 32'h0;
    if (e_if) begin
      chk("fetch_raddr", mem_read_address, if_addr & ~32'h3);
      chk("fetch_funct3", 32'(mem_funct3), 32'd2);
      kind = 1;
      dat  = ref_word(int'(if_addr) % 1024 / 4 * 4);
    end else if (e_d && mis) begin
      kind = 3;
    end else if (e_d && d_we) begin
      chk("st_waddr", mem_write_address, d_addr);
      chk("st_wdata", mem_write_data, d_wdata);
      chk("st_funct3", 32'(mem_funct3), 32'(d_funct3));
      ref_store(a, d_funct3, d_wdata);
    end else if (e_d) begin
      chk("ld_raddr", mem_read_address, d_addr);
      chk("ld_funct3", 32'(mem_funct3), 32'(d_funct3));
      kind = 2;
      dat  = ref_load(a, d_funct3);
    end

    if (reset || !if_req || e_if) streak_m = 0;
    else if (e_d && streak_m < MAX) streak_m++;
    kind_q.push_back(kind);
    exp_q.push_back(dat);
    last_if = e_if;
    last_d  = e_d;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
  endtask

  task automatic new_d();
    int opts [5] = '{0, 1, 2, 4, 5};
    logic [2:0] f3;
    logic we;
    logic [31:0] addr;
    we   = 1'($urandom_range(0, 1));
    f3   = we ? 3'($urandom_range(0, 2)) : 3'(opts[$urandom_range(0, 4)]);
    addr = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 1);
    set_d(we, f3, addr, $urandom);
  endtask

  task automatic run_d(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd);
    logic got = 1'b0;
    if_req = 1'b0;
    set_d(we, f3, addr, wd);
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = last_d;
    end
    chk("d_grant_wait", 32'(got), 32'd1);
    d_req = 1'b0;
    step();
  endtask

  task automatic run_if(logic [31:0] addr);
    logic got = 1'b0;
    d_req = 1'b0;
    if_req = 1'b1;
    if_addr = addr;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = last_if;
    end
    chk("if_grant_wait", 32'(got), 32'd1);
    if_req = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_w[i] = init_word(i);
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = 8'(init_word(i) >> (8 * k));
    end
    streak_m = 0;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    set_d(1'b0, 3'b010, 32'h200, 32'h0);

    // Reset held with both requests pending
    step();
    step();
    reset = 1'b0;
    step();
    chk("first_grant_data", 32'(obs_d), 32'd1);
    d_req = 1'b0;
    step();
    if_req = 1'b0;
    step();

    // Single fetch of a known instruction word
    run_if(32'h10);

    // Store then load back, then misaligned accesses leave memory untouched
    run_d(1'b1, 3'b010, 32'h100, 32'hdead_beef);
    run_d(1'b0, 3'b010, 32'h100, 32'h0);
    chk("load_back", obs_d_rdata, 32'hdead_beef);
    run_d(1'b0, 3'b010, 32'h102, 32'h0);
    run_d(1'b1, 3'b001, 32'h101, 32'h1234_5678);
    run_d(1'b0, 3'b010, 32'h100, 32'h0);
    chk("mem_unchanged", obs_d_rdata, 32'hdead_beef);

    // Both requesters held: data wins MAX times, then fetch
    if_req = 1'b1; if_addr = 32'h20;
    set_d(1'b0, 3'b010, 32'h80, 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("streak_pattern", 32'(obs_if), 32'((i % 5) == 4));
      if (last_d) set_d(1'b0, 3'b010, 32'($urandom_range(0, 255) * 4), 32'h0);
      if (last_if) if_addr = 32'($urandom_range(0, 1023));
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Reset right after a fetch grant swallows the response
    if_req = 1'b1; if_addr = 32'h10;
    step();
    if_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step();
      if (last_d || !d_req) begin
        if ($urandom_range(0, 2) != 0) new_d();
        else d_req = 1'b0;
      end
      if (last_if || !if_req) begin
        if_req = 1'($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 1023));
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
